router_pkt_register: RTL and testbench
======================================

// Module: router_pkt_register
// PURPOSE
//  Parametrised packet input register for the 1xN router. It accepts header, payload and
//  parity bytes from the source port, decodes the destination channel and streams the
//  bytes to the selected FIFO. A HOLD_DEPTH skid buffer absorbs fifo_full back-pressure.
//  Running XOR parity and the received parity byte are compared per packet.
//  Contains its own sequencer; no external FSM state inputs.
// PARAMETERS
//  DATA_W      8  byte width; header = {len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}
//  ADDR_W      2  dest field width; channels 0..2**ADDR_W-2; all-ones addr = invalid
//  HOLD_DEPTH  2  skid buffer entries (>=2)
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           async active-high reset
//  soft_rst     in   1           sync abort of current packet (dest timeout)
//  pkt_vld      in   1           source byte valid (header+payload); low = parity byte
//  data_in      in   DATA_W      source byte
//  fifo_full    in   1           selected destination FIFO full
//  busy         out  1           registered; source must hold data_in while high
//  wr_en        out  1           write strobe to destination FIFO
//  data_out     out  DATA_W      byte to destination FIFO
//  dest         out  ADDR_W      latched destination of current packet
//  low_pkt_vld  out  1           parity byte captured, packet tail pending
//  parity_done  out  1           1-cycle pulse: packet check complete
//  error        out  1           parity mismatch, valid with parity_done, held until next done
//  ovf_err      out  1           sticky: byte arrived with skid buffer full
//  len_err      out  1           length mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffer empty, parity regs 0.
//  Transfer: cycle with !busy and (pkt_vld, or state LOAD and !pkt_vld = parity byte).
//  FSM:
//   IDLE  : pkt_vld & addr!=all-ones -> HDR (latch header/dest, parity<=header).
//           pkt_vld & addr==all-ones -> DROP.
//   HDR   : header into buffer -> LOAD.
//   LOAD  : each pkt_vld transfer pushes byte, parity^=byte. First !pkt_vld transfer
//           captures parity byte, pushes it, low_pkt_vld<=1 -> WAIT.
//   WAIT  : drain buffer; when empty -> CHECK.
//   CHECK : 1 cycle; parity_done=1, error=(int_par!=pkt_par); low_pkt_vld<=0 -> IDLE.
//   DROP  : discard until pkt_vld low, then one more (parity byte) -> IDLE; no wr_en, no done.
//  Output: each cycle buffer non-empty & !fifo_full: wr_en=1, data_out=oldest entry, pop.
//   Push+pop same cycle allowed; count unchanged. Latency: byte at data_in -> wr_en next cycle
//   when buffer empty and !fifo_full.
//  busy <= (count_next!=0 & fifo_full) | count_next>=HOLD_DEPTH-1 | state_next in {HDR,WAIT,CHECK}.
//   Registered: one byte may arrive after buffer fills -> HOLD_DEPTH>=2 covers it.
//   Push at count==HOLD_DEPTH: byte lost, ovf_err<=1 (cleared only by rst).
//  soft_rst: wins over any transfer same cycle; buffer flushed, state IDLE, low_pkt_vld 0,
//   no parity_done, error unchanged.
//  rst mid-packet: immediate return to reset values; partial packet lost.
//  Zero-length packet (len=0): header then parity byte; legal.
// CONFIGURATION
//  ROUTER_REG_LEN_CHECK_EN defined: payload counter (DATA_W-ADDR_W bits) counts LOAD pkt_vld
//   transfers; at CHECK, len_err=(count!=len), valid with parity_done, held like error.
//  Undefined: counter not built, len_err tied 0.
// TESTING
//  rst; hdr 8'h0D (len3,dest1), payload 11,22,33, parity 8'h0D^11^22^33 -> 5 wr_en,
//   dest=1, parity_done pulse, error=0.
//  Same packet with parity 8'hFF -> all 5 bytes written, parity_done, error=1.
//  fifo_full high 4 cycles mid-payload -> busy within 1 cycle, no loss, order kept, ovf_err=0.
//  Header 8'h0B (addr 3) len2 -> DROP, no wr_en, no parity_done, next packet accepted.
//  soft_rst during payload byte 2 -> buffer flushed, IDLE next cycle, no parity_done.
//  LEN_CHECK_EN: header len3 with 2 payload bytes -> parity_done, len_err=1; macro off: len_err=0.

Source files
------------

// File: rtl/router_pkt_register_if.sv
// Source-port and destination-FIFO signal bundle for router_pkt_register.
// The slave modport is the register's view; the master modport is the source/FIFO side.
interface router_pkt_register_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              soft_rst;
  logic              pkt_vld;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              busy;
  logic              wr_en;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] dest;
  logic              low_pkt_vld;
  logic              parity_done;
  logic              error;
  logic              ovf_err;
  logic              len_err;

  modport slave (
    input  soft_rst, pkt_vld, data_in, fifo_full,
    output busy, wr_en, data_out, dest, low_pkt_vld, parity_done, error, ovf_err, len_err
  );

  modport master (
    output soft_rst, pkt_vld, data_in, fifo_full,
    input  busy, wr_en, data_out, dest, low_pkt_vld, parity_done, error, ovf_err, len_err
  );
endinterface

// File: rtl/router_pkt_register.sv
// Packet input register of the 1xN router: header decode, skid buffer, per-packet parity check.
// Optional payload length check is built when ROUTER_REG_LEN_CHECK_EN is defined.
module router_pkt_register #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int HOLD_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  router_pkt_register_if.slave bus
);
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(HOLD_DEPTH);
  localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(HOLD_DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(HOLD_DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] int_par_q, int_par_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic              busy_q, busy_d;
  logic              low_q, low_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [HOLD_DEPTH];

  logic              xfer, push, pop, overflow, store;
  logic [DATA_W-1:0] push_data;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch below can infer a latch.
    state_d   = state_q;
    hdr_d     = hdr_q;
    dest_d    = dest_q;
    int_par_d = int_par_q;
    pkt_par_d = pkt_par_q;
    low_d     = low_q;
    done_d    = 1'b0;
    error_d   = error_q;
    push      = 1'b0;
    push_data = bus.data_in;
    xfer      = !busy_q && (bus.pkt_vld || (state_q == S_LOAD));

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (bus.data_in[ADDR_W-1:0] == '1) begin
            state_d = S_DROP;
          end else begin
            state_d   = S_HDR;
            hdr_d     = bus.data_in;
            dest_d    = bus.data_in[ADDR_W-1:0];
            int_par_d = bus.data_in;
          end
        end
      end
      S_HDR: begin
        push      = 1'b1;
        push_data = hdr_q;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          push = 1'b1;
          if (bus.pkt_vld) begin
            int_par_d = int_par_q ^ bus.data_in;
          end else begin
            pkt_par_d = bus.data_in;
            low_d     = 1'b1;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The check is raised only once the tail byte has left the buffer.
        if (count_q == '0) begin
          state_d = S_CHECK;
          done_d  = 1'b1;
          error_d = (int_par_q != pkt_par_q);
        end
      end
      S_CHECK: begin
        low_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_DROP: begin
        if (!busy_q && !bus.pkt_vld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.soft_rst) begin
      state_d = S_IDLE;
      low_d   = 1'b0;
      done_d  = 1'b0;
      error_d = error_q;
      push    = 1'b0;
    end

    pop      = (count_q != '0) && !bus.fifo_full && !bus.soft_rst;
    overflow = push && !pop && (count_q == DEPTH);
    store    = push && !overflow;

    count_d = count_q;
    if (store && !pop)      count_d = count_q + 1'b1;
    else if (!store && pop) count_d = count_q - 1'b1;
    wr_ptr_d = store ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop   ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    if (bus.soft_rst) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    ovf_d  = ovf_q | overflow;
    // Raised one entry early: the source may still land one byte before it sees busy.
    busy_d = ((count_d != '0) && bus.fifo_full) || (count_d >= BUSY_LVL) ||
             (state_d == S_HDR) || (state_d == S_WAIT) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hdr_q     <= '0;
      dest_q    <= '0;
      int_par_q <= '0;
      pkt_par_q <= '0;
      busy_q    <= 1'b0;
      low_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      dest_q    <= dest_d;
      int_par_q <= int_par_d;
      pkt_par_q <= pkt_par_d;
      busy_q    <= busy_d;
      low_q     <= low_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // NOTE: the skid storage is deliberately not reset; count_q alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.busy        = busy_q;
  assign bus.wr_en       = pop;
  assign bus.data_out    = pop ? mem_q[rd_ptr_q] : '0;
  assign bus.dest        = dest_q;
  assign bus.low_pkt_vld = low_q;
  assign bus.parity_done = done_q;
  assign bus.error       = error_q;
  assign bus.ovf_err     = ovf_q;

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int LEN_W = DATA_W - ADDR_W;

  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic             len_err_q, len_err_d;

  always_comb begin
    len_cnt_d = len_cnt_q;
    len_err_d = len_err_q;
    if (state_q == S_IDLE)                                len_cnt_d = '0;
    else if ((state_q == S_LOAD) && xfer && bus.pkt_vld) len_cnt_d = len_cnt_q + 1'b1;
    if (done_d) len_err_d = (len_cnt_q != hdr_q[DATA_W-1:ADDR_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_cnt_q <= len_cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.len_err = len_err_q;
`else
  assign bus.len_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_pkt_register.sv
// Directed bench for router_pkt_register: packets, parity error, back-pressure, drop, abort, length.
module tb_router_pkt_register;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 2;
  localparam int HOLD_DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  router_pkt_register_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  router_pkt_register #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOLD_DEPTH(HOLD_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  logic [7:0] wr_q [$];
  int         done_cnt     = 0;
  logic       last_err     = 1'b0;
  logic       last_len_err = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_en) wr_q.push_back(bus.data_out);
    if (bus.parity_done) begin
      done_cnt++;
      last_err     = bus.error;
      last_len_err = bus.len_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic vld, input logic [7:0] d);
    logic b;
    int   n;
    n = 0;
    bus.pkt_vld = vld;
    bus.data_in = d;
    do begin
      @(negedge clk);
      b = bus.busy;
      @(posedge clk);
      #1;
      n++;
    end while (b && n < 64);
    if (b) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: byte %h still blocked by busy after %0d cycles", d, n);
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl [4], input int n,
                          input logic [7:0] par);
    send_byte(1'b1, hdr);
    for (int i = 0; i < n; i++) send_byte(1'b1, pl[i]);
    send_byte(1'b0, par);
  endtask

  task automatic wait_done(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) ok = 1'b1;
    end
    idle(2);
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    rst = 1'b1;
    bus.soft_rst = 1'b0; bus.pkt_vld = 1'b0; bus.data_in = '0; bus.fifo_full = 1'b0;
    idle(3);
    outs = {bus.busy, bus.wr_en, bus.data_out, bus.dest, bus.low_pkt_vld,
            bus.parity_done, bus.error, bus.ovf_err, bus.len_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    rst = 1'b0;
    idle(2);
    outs = {bus.busy, bus.wr_en, bus.data_out, bus.dest, bus.low_pkt_vld,
            bus.parity_done, bus.error, bus.ovf_err, bus.len_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h, expected 0", outs);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q [$];
    int d0;
    bit ok;
    exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    wr_q.delete();
    d0 = done_cnt;
    send_byte(1'b1, 8'h0D);
    send_byte(1'b1, 8'h11);
    @(negedge clk);
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.data_out !== 8'h11) begin
      miscompares++;
      $display("FAIL basic_latency: wr_en=%b data_out=%h, expected 1 / 11", bus.wr_en, bus.data_out);
    end
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    send_byte(1'b0, 8'h0D);
    wait_done(d0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_done_timeout: no parity_done"); end
    vectors++;
    if (wr_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      vectors++;
      if (wr_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (bus.dest !== 2'd1) begin miscompares++; $display("FAIL basic_dest: got %0d, expected 1", bus.dest); end
    vectors++;
    if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d, expected 1", done_cnt - d0); end
    vectors++;
    if (last_err !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b, expected 0", last_err); end
    vectors++;
    if (last_len_err !== 1'b0) begin miscompares++; $display("FAIL basic_len_err: got %b, expected 0", last_len_err); end
    vectors++;
    if (bus.low_pkt_vld !== 1'b0) begin miscompares++; $display("FAIL basic_low_pkt_vld: got %b, expected 0", bus.low_pkt_vld); end
  endtask

  task automatic test_parity_error();
    logic [7:0] pl [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
    logic [7:0] exp_q [$];
    int d0;
    bit ok;
    exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF};
    wr_q.delete();
    d0 = done_cnt;
    send_pkt(8'h0D, pl, 3, 8'hFF);
    wait_done(d0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL perr_done_timeout: no parity_done"); end
    vectors++;
    if (wr_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL perr_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      vectors++;
      if (wr_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL perr_byte%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (last_err !== 1'b1) begin miscompares++; $display("FAIL perr_error: got %b, expected 1", last_err); end
    vectors++;
    if (bus.error !== 1'b1) begin miscompares++; $display("FAIL perr_error_held: got %b, expected 1", bus.error); end
  endtask

  task automatic test_soft_rst();
    logic [7:0] pl [4] = '{8'h01, 8'h02, 8'h00, 8'h00};
    logic [7:0] exp_q [$];
    int d0;
    bit ok;
    wr_q.delete();
    d0 = done_cnt;
    send_byte(1'b1, 8'h15);
    send_byte(1'b1, 8'h5A);
    bus.pkt_vld = 1'b1; bus.data_in = 8'h6B; bus.fifo_full = 1'b1; bus.soft_rst = 1'b1;
    @(posedge clk);
    #1;
    bus.soft_rst = 1'b0; bus.fifo_full = 1'b0; bus.pkt_vld = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.wr_en, bus.low_pkt_vld} !== 3'b000) begin
      miscompares++;
      $display("FAIL srst_flush: busy/wr_en/low_pkt_vld=%b, expected 000",
               {bus.busy, bus.wr_en, bus.low_pkt_vld});
    end
    idle(3);
    vectors++;
    if (wr_q.size() !== 1 || wr_q[0] !== 8'h15) begin
      miscompares++;
      $display("FAIL srst_writes: got %0d writes, expected only header 15", wr_q.size());
    end
    vectors++;
    if (done_cnt !== d0) begin miscompares++; $display("FAIL srst_no_done: got %0d pulses, expected 0", done_cnt - d0); end
    vectors++;
    if (bus.error !== 1'b1) begin miscompares++; $display("FAIL srst_error_kept: got %b, expected 1", bus.error); end

    exp_q = '{8'h0A, 8'h01, 8'h02, 8'h09};
    wr_q.delete();
    d0 = done_cnt;
    send_pkt(8'h0A, pl, 2, 8'h09);
    wait_done(d0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL srst_next_timeout: no parity_done"); end
    vectors++;
    if (wr_q !== exp_q) begin
      miscompares++;
      $display("FAIL srst_next_bytes: got %0d writes, expected %0d in order", wr_q.size(), exp_q.size());
    end
    vectors++;
    if (bus.dest !== 2'd2 || last_err !== 1'b0) begin
      miscompares++;
      $display("FAIL srst_next_status: dest=%0d error=%b, expected 2 / 0", bus.dest, last_err);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pl [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] exp_q [$];
    logic       busy_seen, stall_wr;
    int d0;
    bit ok;
    exp_q = '{8'h12, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h16};
    busy_seen = 1'b0;
    stall_wr  = 1'b0;
    wr_q.delete();
    d0 = done_cnt;
    fork
      send_pkt(8'h12, pl, 4, 8'h16);
      begin
        repeat (5) @(posedge clk);
        #1 bus.fifo_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (bus.wr_en) stall_wr = 1'b1;
          if (k == 1) busy_seen = bus.busy;
        end
        @(posedge clk);
        #1 bus.fifo_full = 1'b0;
      end
    join
    wait_done(d0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL bp_done_timeout: no parity_done"); end
    vectors++;
    if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %b one cycle into full, expected 1", busy_seen); end
    vectors++;
    if (stall_wr !== 1'b0) begin miscompares++; $display("FAIL bp_write_while_full: got wr_en while fifo_full"); end
    vectors++;
    if (wr_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL bp_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      vectors++;
      if (wr_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bp_byte%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (bus.ovf_err !== 1'b0 || last_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_flags: ovf_err=%b error=%b, expected 0 / 0", bus.ovf_err, last_err);
    end
  endtask

  task automatic test_drop_and_zero_len();
    logic [7:0] pl [4] = '{8'hC1, 8'hC2, 8'h00, 8'h00};
    logic [7:0] exp_q [$];
    int d0;
    bit ok;
    wr_q.delete();
    d0 = done_cnt;
    send_pkt(8'h0B, pl, 2, 8'h55);
    idle(4);
    vectors++;
    if (wr_q.size() !== 0) begin miscompares++; $display("FAIL drop_writes: got %0d writes, expected 0", wr_q.size()); end
    vectors++;
    if (done_cnt !== d0) begin miscompares++; $display("FAIL drop_done: got %0d pulses, expected 0", done_cnt - d0); end
    vectors++;
    if (bus.dest !== 2'd2) begin miscompares++; $display("FAIL drop_dest: got %0d, expected 2 (unchanged)", bus.dest); end

    exp_q = '{8'h02, 8'h02};
    send_pkt(8'h02, pl, 0, 8'h02);
    wait_done(d0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL zlen_done_timeout: no parity_done"); end
    vectors++;
    if (wr_q !== exp_q) begin
      miscompares++;
      $display("FAIL zlen_bytes: got %0d writes, expected 02 02", wr_q.size());
    end
    vectors++;
    if (last_err !== 1'b0 || last_len_err !== 1'b0) begin
      miscompares++;
      $display("FAIL zlen_flags: error=%b len_err=%b, expected 0 / 0", last_err, last_len_err);
    end
  endtask

  task automatic test_len_mismatch();
    logic [7:0] pl [4] = '{8'h44, 8'h55, 8'h00, 8'h00};
    logic       exp_len;
    int d0;
    bit ok;
`ifdef ROUTER_REG_LEN_CHECK_EN
    exp_len = 1'b1;
`else
    exp_len = 1'b0;
`endif
    wr_q.delete();
    d0 = done_cnt;
    send_pkt(8'h0D, pl, 2, 8'h1C);
    wait_done(d0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL len_done_timeout: no parity_done"); end
    vectors++;
    if (last_len_err !== exp_len) begin
      miscompares++;
      $display("FAIL len_err: got %b, expected %b", last_len_err, exp_len);
    end
    vectors++;
    if (last_err !== 1'b0 || wr_q.size() !== 4) begin
      miscompares++;
      $display("FAIL len_pkt: error=%b writes=%0d, expected 0 / 4", last_err, wr_q.size());
    end
  endtask

  task automatic test_rst_mid_packet();
    logic [16:0] outs;
    send_byte(1'b1, 8'h0D);
    send_byte(1'b1, 8'h77);
    bus.pkt_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    outs = {bus.busy, bus.wr_en, bus.data_out, bus.dest, bus.low_pkt_vld,
            bus.parity_done, bus.error, bus.ovf_err, bus.len_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_packet: got %h, expected 0", outs);
    end
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_soft_rst();
    test_backpressure();
    test_drop_and_zero_len();
    test_len_mismatch();
    test_rst_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
